vm: RTL and testbench



---
 rtl/vm.sv | 82 ++++++++
 tb/tb_vm.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/vm.sv
// Two-item coin vending controller: latches a Coke/Pepsi selection, accumulates
// 5/10 coins in units of 5, and pulses dispense/change codes for one cycle.
module vm (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic       cancel,
  output logic [1:0] y,
  output logic [1:0] c
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COKE  = 2'd1,
    PEPSI = 2'd2
  } state_t;

  state_t     state_q;
  logic [1:0] credit_q;
  logic [1:0] y_q;
  logic [1:0] c_q;

  logic [1:0] coin;
  logic [1:0] price;
  logic [2:0] total;
  logic [1:0] change;

  // Coin and price in units of 5; b = 11 is treated as no coin.
  always_comb begin
    coin = 2'd0;
    if (b == 2'b01) coin = 2'd1;
    else if (b == 2'b10) coin = 2'd2;
    price  = (state_q == PEPSI) ? 2'd3 : 2'd2;
    total  = {1'b0, credit_q} + {1'b0, coin};
    // Modulo-4 subtraction is exact here: total never exceeds price + 1.
    change = total[1:0] - price;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      credit_q <= '0;
      y_q      <= '0;
      c_q      <= '0;
    end else begin
      y_q <= '0;
      c_q <= '0;
      case (state_q)
        IDLE: begin
          credit_q <= '0;
          if (a == 2'b01)      state_q <= COKE;
          else if (a == 2'b10) state_q <= PEPSI;
        end
        COKE, PEPSI: begin
          if (cancel) begin
            c_q      <= credit_q;
            credit_q <= '0;
            state_q  <= IDLE;
          end else if (coin != 2'd0) begin
            if (total >= {1'b0, price}) begin
              y_q      <= (state_q == COKE) ? 2'b01 : 2'b10;
              c_q      <= change;
              credit_q <= '0;
              state_q  <= IDLE;
            end else begin
              credit_q <= total[1:0];
            end
          end
        end
        default: begin
          state_q  <= IDLE;
          credit_q <= '0;
        end
      endcase
    end
  end

  assign y = y_q;
  assign c = c_q;

endmodule

// File: tb/tb_vm.sv
// Bench for vm: directed scenarios then random traffic, compared against a
// money-level model of the vending rules.
module tb_vm;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] a;
  logic [1:0] b;
  logic       cancel;
  logic [1:0] y;
  logic [1:0] c;

  int vectors    = 0;
  int miscompares = 0;

  // Reference model state in money: price of the selected item (0 = none).
  int m_price  = 0;
  int m_credit = 0;
  logic [1:0] exp_y;
  logic [1:0] exp_c;

  vm dut (
    .clk   (clk),
    .reset (reset),
    .a     (a),
    .b     (b),
    .cancel(cancel),
    .y     (y),
    .c     (c)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] expv);
    vectors++;
    assert (obs === expv)
    else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  task automatic model_edge(input logic [1:0] ai, input logic [1:0] bi, input logic ci);
    int coin;
    int total;
    exp_y = 2'b00;
    exp_c = 2'b00;
    if (m_price == 0) begin
      if (ai == 2'b01)      begin m_price = 10; m_credit = 0; end
      else if (ai == 2'b10) begin m_price = 15; m_credit = 0; end
    end else if (ci) begin
      exp_c    = 2'(m_credit / 5);
      m_price  = 0;
      m_credit = 0;
    end else begin
      coin = (bi == 2'b01) ? 5 : (bi == 2'b10) ? 10 : 0;
      if (coin != 0) begin
        total = m_credit + coin;
        if (total >= m_price) begin
          exp_y    = (m_price == 10) ? 2'b01 : 2'b10;
          exp_c    = 2'((total - m_price) / 5);
          m_price  = 0;
          m_credit = 0;
        end else begin
          m_credit = total;
        end
      end
    end
  endtask

  // Called shortly after a rising edge: drive, wait one edge, compare.
  task automatic step(input string tag, input logic [1:0] ai, input logic [1:0] bi, input logic ci);
    a = ai; b = bi; cancel = ci;
    @(posedge clk);
    model_edge(ai, bi, ci);
    #1;
    check({tag, ".y"}, y, exp_y);
    check({tag, ".c"}, c, exp_c);
  endtask

  // Asynchronous reset pulse asserted mid-cycle; outputs must clear at once.
  task automatic mid_reset(input string tag);
    #2 reset = 1'b1;
    #1;
    m_price = 0; m_credit = 0;
    check({tag, ".imm_y"}, y, 2'b00);
    check({tag, ".imm_c"}, c, 2'b00);
    @(posedge clk);
    #1;
    check({tag, ".held_y"}, y, 2'b00);
    check({tag, ".held_c"}, c, 2'b00);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; a = 2'b00; b = 2'b00; cancel = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("por.y", y, 2'b00);
    check("por.c", c, 2'b00);
    reset = 1'b0;

    step("idle_coin", 2'b00, 2'b10, 1'b0);
    step("idle_gap",  2'b00, 2'b00, 1'b0);

    step("c10.sel",  2'b01, 2'b00, 1'b0);
    step("c10.coin", 2'b00, 2'b10, 1'b0);
    step("c10.post", 2'b00, 2'b00, 1'b0);

    step("c5_10.sel", 2'b01, 2'b00, 1'b0);
    step("c5_10.c1",  2'b00, 2'b01, 1'b0);
    step("c5_10.gap", 2'b00, 2'b00, 1'b0);
    step("c5_10.c2",  2'b00, 2'b10, 1'b0);

    step("p10_10.sel", 2'b10, 2'b00, 1'b0);
    step("p10_10.c1",  2'b00, 2'b10, 1'b0);
    step("p10_10.gap", 2'b00, 2'b00, 1'b0);
    step("p10_10.c2",  2'b00, 2'b10, 1'b0);

    step("p5_10.sel", 2'b10, 2'b00, 1'b0);
    step("p5_10.c1",  2'b00, 2'b01, 1'b0);
    step("p5_10.gap", 2'b00, 2'b00, 1'b0);
    step("p5_10.c2",  2'b00, 2'b10, 1'b0);

    step("p10_5.sel", 2'b10, 2'b00, 1'b0);
    step("p10_5.c1",  2'b00, 2'b10, 1'b0);
    step("p10_5.c11", 2'b00, 2'b11, 1'b0);
    step("p10_5.c2",  2'b00, 2'b01, 1'b0);

    step("pcan.sel", 2'b10, 2'b00, 1'b0);
    step("pcan.c1",  2'b01, 2'b10, 1'b0);
    step("pcan.can", 2'b00, 2'b00, 1'b1);
    step("pcan.post", 2'b00, 2'b00, 1'b0);

    step("ccan.sel",  2'b01, 2'b00, 1'b0);
    step("ccan.c1",   2'b00, 2'b01, 1'b0);
    step("ccan.can",  2'b00, 2'b10, 1'b1);

    // Back-to-back: new selection accepted during the pulse cycle.
    step("b2b.sel",  2'b01, 2'b00, 1'b0);
    step("b2b.coin", 2'b00, 2'b10, 1'b0);
    step("b2b.sel2", 2'b10, 2'b00, 1'b0);
    step("b2b.c1",   2'b00, 2'b10, 1'b0);
    step("b2b.c2",   2'b00, 2'b01, 1'b0);

    step("rst.sel", 2'b10, 2'b00, 1'b0);
    step("rst.c1",  2'b00, 2'b10, 1'b0);
    mid_reset("rst_credit");
    step("rst.sel2", 2'b01, 2'b00, 1'b0);
    step("rst.coin", 2'b00, 2'b10, 1'b0);

    step("pulse.sel", 2'b01, 2'b00, 1'b0);
    step("pulse.coin", 2'b00, 2'b10, 1'b0);
    mid_reset("rst_pulse");

    for (int unsigned i = 0; i < 400; i++) begin
      logic [1:0] ra;
      logic [1:0] rb;
      logic       rc;
      ra = 2'($urandom_range(0, 3));
      rb = ($urandom_range(0, 2) == 0) ? 2'b00 : 2'($urandom_range(0, 3));
      rc = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 59) == 0) mid_reset("rnd_rst");
      else step("rnd", ra, rb, rc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
